// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Requesting-side sequencer for the M-extension divide unit. Accepts
// DIV/DIVU/REM/REMU from execute, drives the shared signed divider, applies the
// RISC-V zero-divisor result rules, and runs unsigned operations the signed
// divider cannot represent (either operand MSB set) through a local 32-cycle
// restoring shift-subtract loop. Results go to writeback over valid/ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_funct3, req_a, req_b   operation code, dividend, divisor
//   req_tag                    destination tag, returned with the result
//   flush                      synchronous kill of any in-flight operation
//   div_oper_a/b, div_fuct3    divider operands and quotient(1)/remainder(0)
//   div_enable                 divider enable, high only while issuing
//   div_result, div_finish     divider result and completion
//   div_dz                     divider zero-divisor indication
//   res_valid/res_ready        result handshake
//   res_data, res_tag, res_dz  result value, tag, zero-divisor flag
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAGW-1:0]  req_tag,
    input  logic             flush,
    output logic [WIDTH-1:0] div_oper_a,
    output logic [WIDTH-1:0] div_oper_b,
    output logic             div_fuct3,
    output logic             div_enable,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_finish,
    input  logic             div_dz,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [TAGW-1:0]  res_tag,
    output logic             res_dz
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_USEQ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rem_op_q, rem_op_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [4:0]       cnt_q, cnt_d;

    logic             req_ready_q, req_ready_d;
    logic             div_en_q, div_en_d;
    logic [WIDTH-1:0] div_a_q, div_a_d;
    logic [WIDTH-1:0] div_b_q, div_b_d;
    logic             div_f3_q, div_f3_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [TAGW-1:0]  res_tag_q, res_tag_d;
    logic             res_dz_q, res_dz_d;

    logic             req_rem_s;
    logic             req_uns_s;
    logic             req_slow_s;
    logic [WIDTH+1:0] r_sh_s;
    logic [WIDTH+1:0] diff_s;
    logic             step_ge_s;
    logic [WIDTH:0]   r_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             dz_s;

    // Request decode: codes with funct3[2] clear behave as signed DIV.
    always_comb begin
        if (req_funct3[2]) begin
            req_rem_s = req_funct3[1];
            req_uns_s = req_funct3[0];
        end else begin
            req_rem_s = 1'b0;
            req_uns_s = 1'b0;
        end
        req_slow_s = req_uns_s && (req_b != {WIDTH{1'b0}}) && (req_a[WIDTH-1] || req_b[WIDTH-1]);
    end

    // One restoring step: shift {R,Q} left, keep R - divisor when it does not borrow.
    always_comb begin
        r_sh_s    = {r_q, quo_q[WIDTH-1]};
        diff_s    = r_sh_s - {2'b00, b_q};
        step_ge_s = ~diff_s[WIDTH+1];
        if (step_ge_s) begin
            r_step_s = diff_s[WIDTH:0];
        end else begin
            r_step_s = r_sh_s[WIDTH:0];
        end
        q_step_s = {quo_q[WIDTH-2:0], step_ge_s};
        dz_s     = div_dz || (b_q == {WIDTH{1'b0}});
    end

    // Next-state and next-output computation; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_op_d   = rem_op_q;
        tag_d      = tag_q;
        r_d        = r_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        div_f3_d   = div_f3_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        res_dz_d   = res_dz_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    rem_op_d = req_rem_s;
                    tag_d    = req_tag;
                    if (req_slow_s) begin
                        state_d = S_USEQ;
                        r_d     = {(WIDTH+1){1'b0}};
                        quo_d   = req_a;
                        cnt_d   = 5'd0;
                    end else begin
                        state_d  = S_ISSUE;
                        div_a_d  = req_a;
                        div_b_d  = req_b;
                        div_f3_d = ~req_rem_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (div_finish) begin
                    state_d  = S_DONE;
                    div_a_d  = {WIDTH{1'b0}};
                    div_b_d  = {WIDTH{1'b0}};
                    div_f3_d = 1'b0;
                    if (dz_s) begin
                        res_data_d = rem_op_q ? a_q : {WIDTH{1'b1}};
                    end else begin
                        res_data_d = div_result;
                    end
                    res_tag_d = tag_q;
                    res_dz_d  = dz_s;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_USEQ: begin
                r_d   = r_step_s;
                quo_d = q_step_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d    = S_DONE;
                    res_data_d = rem_op_q ? r_step_s[WIDTH-1:0] : q_step_s;
                    res_tag_d  = tag_q;
                    res_dz_d   = 1'b0;
                end else begin
                    state_d = S_USEQ;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d    = S_IDLE;
                    res_data_d = {WIDTH{1'b0}};
                    res_tag_d  = {TAGW{1'b0}};
                    res_dz_d   = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d    = S_IDLE;
            div_a_d    = {WIDTH{1'b0}};
            div_b_d    = {WIDTH{1'b0}};
            div_f3_d   = 1'b0;
            res_data_d = {WIDTH{1'b0}};
            res_tag_d  = {TAGW{1'b0}};
            res_dz_d   = 1'b0;
        end else begin
            state_d = state_d;
        end

        // Handshake/enable outputs are registered decodes of the next state.
        req_ready_d = (state_d == S_IDLE);
        div_en_d    = (state_d == S_ISSUE);
        res_valid_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            rem_op_q    <= 1'b0;
            tag_q       <= {TAGW{1'b0}};
            r_q         <= {(WIDTH+1){1'b0}};
            quo_q       <= {WIDTH{1'b0}};
            cnt_q       <= 5'd0;
            req_ready_q <= 1'b1;
            div_en_q    <= 1'b0;
            div_a_q     <= {WIDTH{1'b0}};
            div_b_q     <= {WIDTH{1'b0}};
            div_f3_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= {WIDTH{1'b0}};
            res_tag_q   <= {TAGW{1'b0}};
            res_dz_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rem_op_q    <= rem_op_d;
            tag_q       <= tag_d;
            r_q         <= r_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            div_en_q    <= div_en_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            div_f3_q    <= div_f3_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_dz_q    <= res_dz_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign div_enable = div_en_q;
    assign div_oper_a = div_a_q;
    assign div_oper_b = div_b_q;
    assign div_fuct3  = div_f3_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign res_dz     = res_dz_q;

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencing controller on the requesting side of the M-extension divide interface. It accepts DIV/DIVU/REM/REMU operations from the execute stage and drives the divider's `oper_a`/`oper_b`/`fuct3`/`enable_div` inputs. It captures `div_o`, `div_finish` and `divided_by_zero`, and applies RISC-V result rules. Unsigned operations the signed divider cannot represent go to an internal 32-cycle shift-subtract sequencer. Results are returned to writeback through a valid/ready handshake.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `TAGW`, 5: destination-register tag width.

- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  execute stage presents an operation
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_funct3`  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are treated as DIV
- `req_a`, `req_b`  in  WIDTH  dividend, divisor
- `req_tag`  in  TAGW  destination tag, returned unchanged
- `flush`  in  1  synchronous kill of any in-flight operation
- `div_oper_a`, `div_oper_b`  out  WIDTH  to divider operands
- `div_fuct3`  out  1  to divider: 1 = quotient, 0 = remainder
- `div_enable`  out  1  to divider enable
- `div_result`  in  WIDTH  divider `div_o`
- `div_finish`  in  1  divider completion
- `div_dz`  in  1  divider `divided_by_zero`
- `res_valid`  out  1  result available
- `res_ready`  in  1  writeback accepts the result
- `res_data`  out  WIDTH  final result
- `res_tag`  out  TAGW  tag of the result
- `res_dz`  out  1  the operation had a zero divisor

## Operation
- States: IDLE, ISSUE, USEQ, DONE.
- Reset (async, `rst_n` = 0): state = IDLE. Every output is 0 except `req_ready`, which is 1.
- IDLE: `req_ready` = 1. When `req_valid` is high, register operands, funct3 and tag.
  - Go to USEQ if the op is unsigned (funct3[0] = 1), `req_b` != 0, and (`req_a`[31] | `req_b`[31]) is set.
  - Otherwise go to ISSUE. This fast path covers all signed ops, unsigned ops with both MSBs clear, and any zero divisor.
- ISSUE: `div_enable` = 1. Operand registers drive `div_oper_a`/`div_oper_b`. `div_fuct3` = ~funct3[1].
  - If `div_finish` is seen, latch the result and go to DONE.
  - If `div_finish` is not seen, stay in ISSUE with operands held stable.
- Zero divisor (`div_dz` = 1, or registered divisor == 0):
  - quotient ops: `res_data` = 0xFFFFFFFF
  - remainder ops: `res_data` = registered dividend
  - `res_dz` = 1 in both cases.
- Signed overflow (0x80000000 / 0xFFFFFFFF) is taken from the divider: quotient 0x80000000, remainder 0. No fixup is applied.
- USEQ: restoring unsigned division.
  - Datapath: 33-bit partial remainder `R`, 32-bit quotient `Q`, 5-bit iteration counter.
  - Initialise: R = 0, Q = dividend, cnt = 0.
  - Each cycle: shift {R,Q} left by 1, trial = R − {0,divisor}. If trial ≥ 0, R = trial and Q[0] = 1; otherwise Q[0] = 0.
  - After the iteration with cnt = 31, latch Q (DIVU) or R[31:0] (REMU) and go to DONE.
  - `div_enable` = 0 throughout USEQ.
- DONE: `res_valid` = 1. `res_data`, `res_tag` and `res_dz` are stable.
  - Leave to IDLE on `res_valid && res_ready`.
  - A new request is not accepted in the same cycle.
- `flush`: from any state, go to IDLE on the next edge. Drop any latched result; `res_valid` = 0 from the next cycle. `flush` has priority over `res_ready` and `req_valid`.
- `div_enable` is deasserted in every state except ISSUE. The divider sees zero operands when idle.

## Timing
- Request accepted at edge 0 (`req_valid && req_ready`).
- Fast path: ISSUE during cycle 1, `res_valid` from cycle 2. Latency 2 cycles.
- Slow path: USEQ during cycles 1–32, `res_valid` from cycle 33. Latency 33 cycles.
- `res_*` hold unchanged while `res_valid && !res_ready`.
- Throughput: one operation per (latency + 1) cycles at best. `req_ready` returns in the cycle after handoff.
- Async reset mid-USEQ or mid-DONE: outputs clear immediately, with no result emitted.

## Test plan
- Fast path: DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. `res_valid` 2 cycles after accept; `div_enable` high exactly 1 cycle.
- Zero divisor: DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIVU 0xFFFFFFFF/0 → 0xFFFFFFFF via fast path. `res_dz` = 1 in all cases.
- Slow path: DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU → 1. `res_valid` exactly 33 cycles after accept; `div_enable` stays 0.
- Overflow and small unsigned:
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - DIVU 100 / 7 → 14 via fast path.
- Backpressure: `res_ready` held low for 10 cycles → `res_valid`, `res_data` and `res_tag` (0x1A) stable, `req_ready` = 0. Handoff on `res_ready`, then `req_ready` = 1 the next cycle.
- Flush at cycle 10 of USEQ → IDLE next cycle, no `res_valid`. A following DIV 9/3 returns 3 with the correct new tag.
